// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - time-multiplexed BCD 7-segment scan driver with guard, blanking, blink and dp
module seg7_scan_display #(
    parameter int NUM_DIGITS     = 6,
    parameter int SCAN_DIV       = 1000,
    parameter int GUARD          = 8,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic [4*NUM_DIGITS-1:0]   i_bcd_in,
    input  logic [NUM_DIGITS-1:0]     i_blink_mask,
    input  logic [NUM_DIGITS-1:0]     i_dp_mask,
    input  logic                      i_lz_blank,
    output logic [6:0]                o_seg,
    output logic                      o_dp,
    output logic [NUM_DIGITS-1:0]     o_an,
    output logic                      o_frame_done
);

    localparam int DIV_W = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int IDX_W = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] GUARD_CMP = DIV_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

    // "off" levels of the pads, so dark slots and reset share one definition
    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [DIV_W-1:0]        r_div_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [BLK_W-1:0]        r_blink_cnt;
    logic                    r_blink_ph;
    logic [4*NUM_DIGITS-1:0] r_snap;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_frame_start;
    logic [3:0]              w_digit;
    logic                    w_dp_sel;
    logic                    w_blink_sel;
    logic                    w_lz_sel;
    logic [NUM_DIGITS-1:0]   w_lz_zero;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic                    w_blank;
    logic                    w_show;
    logic [6:0]              w_seg_raw;

    assign w_slot_end    = (r_div_cnt == DIV_LAST);
    assign w_frame_end   = w_slot_end && (r_idx == IDX_LAST);
    assign w_frame_start = (r_div_cnt == '0) && (r_idx == '0);

    // Slot divider and digit index; both freeze while scanning is disabled
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div_cnt <= '0;
            r_idx     <= '0;
        end else if (i_en) begin
            if (w_slot_end) begin
                r_div_cnt <= '0;
                r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    // Blink phase toggles after every BLINK_FRAMES completed frames
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (i_en && w_frame_end) begin
            if (r_blink_cnt == BLK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Capture all digits at the first cycle of a frame so a frame never mixes two counter values
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_snap <= '0;
        end else if (i_en && w_frame_start) begin
            r_snap <= i_bcd_in;
        end
    end

    // Leading-zero run: w_lz_zero[k] set when snapshot digits k..top are all zero
    always_comb begin
        logic w_run;
        w_run     = 1'b1;
        w_lz_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_run        = w_run && (r_snap[4*k +: 4] == 4'd0);
            w_lz_zero[k] = w_run;
        end
    end

    // Per-slot selection of digit value, masks and anode position
    always_comb begin
        w_digit     = 4'd0;
        w_dp_sel    = 1'b0;
        w_blink_sel = 1'b0;
        w_lz_sel    = 1'b0;
        w_onehot    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_digit     = r_snap[4*k +: 4];
                w_dp_sel    = i_dp_mask[k];
                w_blink_sel = i_blink_mask[k];
                w_lz_sel    = w_lz_zero[k];
                w_onehot[k] = 1'b1;
            end
        end
    end

    // Whole-slot blanking: blink phase or leading zero (rightmost digit always shown)
    always_comb begin
        w_blank = (w_blink_sel && r_blink_ph) ||
                  (i_lz_blank && (r_idx != '0) && w_lz_sel);
        w_show  = i_en && (r_div_cnt >= GUARD_CMP) && !w_blank;
    end

    // BCD to active-high gfedcba; codes 10-15 show a dash
    always_comb begin
        w_seg_raw = 7'h40;
        case (w_digit)
            4'd0: w_seg_raw = 7'h3F;
            4'd1: w_seg_raw = 7'h06;
            4'd2: w_seg_raw = 7'h5B;
            4'd3: w_seg_raw = 7'h4F;
            4'd4: w_seg_raw = 7'h66;
            4'd5: w_seg_raw = 7'h6D;
            4'd6: w_seg_raw = 7'h7D;
            4'd7: w_seg_raw = 7'h07;
            4'd8: w_seg_raw = 7'h7F;
            4'd9: w_seg_raw = 7'h6F;
            default: w_seg_raw = 7'h40;
        endcase
    end

    // Registered pad drive with polarity applied last; dark during guard, blanking or disable
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_an         <= AN_OFF;
            o_seg        <= SEG_OFF;
            o_dp         <= DP_OFF;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= i_en && w_frame_end;
            if (w_show) begin
                o_an  <= AN_ACTIVE_LOW  ? ~w_onehot  : w_onehot;
                o_seg <= SEG_ACTIVE_LOW ? ~w_seg_raw : w_seg_raw;
                o_dp  <= SEG_ACTIVE_LOW ? ~w_dp_sel  : w_dp_sel;
            end else begin
                o_an  <= AN_OFF;
                o_seg <= SEG_OFF;
                o_dp  <= DP_OFF;
            end
        end
    end

endmodule
